ula_181_seq: RTL

//  Parametrised, sequenced successor to the 4-bit 74181-style ULA: one SLICE_W-bit slice per clock,

---
 rtl/ula_181_seq_if.sv | 31 +++
 rtl/ula_181_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ula_181_seq_if.sv
// Handshake/operand bus for the sequenced 74181-style ULA.
// The slave modport is the ULA side. The master modport is the producer/consumer side.
interface ula_181_seq_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       s;
  logic             m;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             c_out;
  logic             ovf;
  logic             zero;
  logic             a_eq_b;
  logic             busy;

  modport master (
    output in_valid, a, b, s, m, c_in, out_ready,
    input  in_ready, out_valid, f, c_out, ovf, zero, a_eq_b, busy
  );

  modport slave (
    input  in_valid, a, b, s, m, c_in, out_ready,
    output in_ready, out_valid, f, c_out, ovf, zero, a_eq_b, busy
  );
endinterface

// File: rtl/ula_181_seq.sv
// Sequenced 74181-style ULA. It evaluates one SLICE_W-bit slice per clock.
// The ripple carry between slices is held in a register, which behaves like
// cascaded 74181 chips spread out in time.
module ula_181_seq #(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  ula_181_seq_if.slave   bus
);

  localparam int NS = WIDTH / SLICE_W;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [3:0]         r_s;
  logic               r_m;
  logic               r_carry;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_f;
  logic               r_c_out;
  logic               r_ovf;
  logic               r_zero;
  logic               r_a_eq_b;
  logic               r_out_valid;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_last;
  logic [SLICE_W-1:0] w_as;
  logic [SLICE_W-1:0] w_bs;
  logic [SLICE_W-1:0] w_t1;
  logic [SLICE_W-1:0] w_t2;
  logic [SLICE_W:0]   w_sum;
  logic [SLICE_W-1:0] w_fs;
  logic               w_cout;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_f_next;

  // Handshake decode: a finished result that is being consumed frees the block on the same edge.
  always_comb begin
    w_in_ready = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
    w_accept   = bus.in_valid && w_in_ready;
    w_last     = (r_cnt == CW'(NS - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    if (bus.out_ready) w_state_next = w_accept ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Slice evaluation. The current slice is selected by the counter, and the
  // result is merged into f at that slice's position.
  always_comb begin
    w_as     = '0;
    w_bs     = '0;
    w_t1     = '0;
    w_t2     = '0;
    w_fs     = '0;
    w_cout   = 1'b0;
    w_ovf    = 1'b0;
    w_f_next = r_f;
    for (int unsigned k = 0; k < NS; k++) begin
      if (r_cnt == CW'(k)) begin
        w_as = r_a[k*SLICE_W +: SLICE_W];
        w_bs = r_b[k*SLICE_W +: SLICE_W];
      end
    end
    case (r_s[1:0])
      2'b00: w_t1 = w_as;
      2'b01: w_t1 = w_as | w_bs;
      2'b10: w_t1 = w_as | ~w_bs;
      default: w_t1 = '1;
    endcase
    case (r_s[3:2])
      2'b00: w_t2 = '0;
      2'b01: w_t2 = w_as & ~w_bs;
      2'b10: w_t2 = w_as & w_bs;
      default: w_t2 = w_as;
    endcase
    w_sum = {1'b0, w_t1} + {1'b0, w_t2} + {{SLICE_W{1'b0}}, r_carry};
    if (r_m) begin
      case (r_s)
        4'b0000: w_fs = ~w_as;
        4'b0001: w_fs = ~(w_as | w_bs);
        4'b0010: w_fs = ~w_as & w_bs;
        4'b0011: w_fs = '0;
        4'b0100: w_fs = ~(w_as & w_bs);
        4'b0101: w_fs = ~w_bs;
        4'b0110: w_fs = w_as ^ w_bs;
        4'b0111: w_fs = w_as & ~w_bs;
        4'b1000: w_fs = ~w_as | w_bs;
        4'b1001: w_fs = ~(w_as ^ w_bs);
        4'b1010: w_fs = w_bs;
        4'b1011: w_fs = w_as & w_bs;
        4'b1100: w_fs = '1;
        4'b1101: w_fs = w_as | ~w_bs;
        4'b1110: w_fs = w_as | w_bs;
        default: w_fs = w_as;
      endcase
    end else begin
      w_fs   = w_sum[SLICE_W-1:0];
      w_cout = w_sum[SLICE_W];
      // The carry into the MSB is recovered from the sum bit and the two term bits.
      w_ovf  = (w_sum[SLICE_W-1] ^ w_t1[SLICE_W-1] ^ w_t2[SLICE_W-1]) ^ w_cout;
    end
    for (int unsigned k = 0; k < NS; k++) begin
      if (r_cnt == CW'(k)) w_f_next[k*SLICE_W +: SLICE_W] = w_fs;
    end
  end

  // Datapath: operand capture, per-slice result and carry, and final flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_s         <= '0;
      r_m         <= 1'b0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_f         <= '0;
      r_c_out     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_a_eq_b    <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_a         <= bus.a;
      r_b         <= bus.b;
      r_s         <= bus.s;
      r_m         <= bus.m;
      r_carry     <= bus.c_in & ~bus.m;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else if (r_state == RUN) begin
      r_f     <= w_f_next;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_out_valid <= 1'b1;
        r_c_out     <= w_cout;
        r_ovf       <= w_ovf;
        r_zero      <= (w_f_next == '0);
        r_a_eq_b    <= (r_a == r_b);
      end
    end else if ((r_state == DONE) && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.f         = r_f;
  assign bus.c_out     = r_c_out;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;
  assign bus.a_eq_b    = r_a_eq_b;
  assign bus.busy      = (r_state == RUN);

endmodule
